// File: rtl/alu_scheduler.sv
// Two-port ALU scheduler: arbitrates sequencer (port 0) and counter-increment
// unit (port 1) requests, launches one op at a time and reports completion.
module alu_scheduler #(
  parameter int unsigned LAT_ADD    = 2,
  parameter int unsigned LAT_MP     = 4,
  parameter int unsigned LAT_DV     = 6,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic       alu_start,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       grant
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned STV_W = 2;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic             grant_q, grant_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             err_q, err_d, start_q, start_d;

  logic             v0, v1, starved, win0, win1, illegal, legal_win;
  logic [OP_W-1:0]  win_op;

  function automatic logic [CNT_W-1:0] lat_m1(input logic [OP_W-1:0] op);
    case (op)
      3'd3, 3'd4: return CNT_W'(LAT_MP - 1);
      3'd5, 3'd6: return CNT_W'(LAT_DV - 1);
      default:    return CNT_W'(LAT_ADD - 1);
    endcase
  endfunction

  // A request acked this cycle is already consumed, even if valid is still seen high.
  assign v0        = req0_valid & ~ack0_q;
  assign v1        = req1_valid & ~ack1_q;
  assign starved   = (starve_q == STV_W'(STARVE_MAX));
  assign win0      = (state_q == IDLE) & v0 & ~(v1 & starved);
  assign win1      = (state_q == IDLE) & v1 & ~win0;
  assign win_op    = win1 ? req1_op : req0_op;
  assign illegal   = win1 ? (req1_op > 3'd1) : (req0_op == 3'd7);
  assign legal_win = (win0 | win1) & ~illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      alu_op_q <= '0;
      grant_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      alu_op_q <= alu_op_d;
      grant_q  <= grant_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err_q    <= err_d;
      start_q  <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (legal_win) state_d = EXEC;
      EXEC:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for counter, starvation tracking and the registered pulses.
  always_comb begin
    cnt_d    = cnt_q;
    starve_d = starve_q;
    alu_op_d = alu_op_q;
    grant_d  = grant_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = 1'b0;
    start_d  = 1'b0;
    if (state_q == IDLE) begin
      ack0_d = win0;
      ack1_d = win1;
      err_d  = (win0 | win1) & illegal;
      if (!v1 || win1)          starve_d = '0;
      else if (win0 && !starved) starve_d = starve_q + STV_W'(1);
      if (legal_win) begin
        start_d  = 1'b1;
        alu_op_d = win_op;
        grant_d  = win1;
        cnt_d    = lat_m1(win_op);
      end
    end else if (cnt_q == '0) begin
      done0_d = ~grant_q;
      done1_d = grant_q;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign alu_start = start_q;
  assign alu_op    = alu_op_q;
  assign grant     = grant_q;
  assign busy      = (state_q == EXEC);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler with hand-computed expectations.
module tb_alu_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic       ack0, ack1, done0, done1, err, alu_start, busy, grant;
  logic [2:0] alu_op;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  alu_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_op(req1_op),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .err(err),
    .alu_start(alu_start), .alu_op(alu_op), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " outs"}, {28'd0, ack0, ack1, done0, done1}, 32'd0);
    check({tag, " err/start/busy"}, {29'd0, err, alu_start, busy}, 32'd0);
    check({tag, " alu_op/grant"}, {28'd0, alu_op, grant}, 32'd0);
  endtask

  int launch_cyc[8];
  int launch_gnt[8];
  int found;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0;
    req1_valid = 1'b0; req1_op = 3'd0;
    #2;
    check_all_zero("reset");
    tick(); tick();
    check_all_zero("reset held");
    rst = 1'b0;

    // Single AD on port 0
    req0_valid = 1'b1; req0_op = 3'd0;
    tick();
    check("ad ack0", 32'(ack0), 1);
    check("ad start", 32'(alu_start), 1);
    check("ad op", 32'(alu_op), 0);
    check("ad busy A", 32'(busy), 1);
    req0_valid = 1'b0;
    tick();
    check("ad busy A+1", 32'(busy), 1);
    check("ad pulses A+1", {29'd0, ack0, alu_start, done0}, 0);
    tick();
    check("ad done0", 32'(done0), 1);
    check("ad busy done", 32'(busy), 0);

    // DV0 with port 1 waiting
    req0_valid = 1'b1; req0_op = 3'd5;
    req1_valid = 1'b1; req1_op = 3'd0;
    tick();
    check("dv start", 32'(alu_start), 1);
    check("dv op", 32'(alu_op), 5);
    check("dv grant", 32'(grant), 0);
    req0_valid = 1'b0;
    for (int i = 1; i < 6; i++) begin
      tick();
      check("dv busy", 32'(busy), 1);
      check("dv no ack1", {30'd0, ack1, done0}, 0);
    end
    tick();
    check("dv done0", 32'(done0), 1);
    check("dv idle", 32'(busy), 0);
    check("dv ack1 late", 32'(ack1), 0);
    tick();
    check("p1 ack1", 32'(ack1), 1);
    check("p1 start", 32'(alu_start), 1);
    check("p1 grant", 32'(grant), 1);
    req1_valid = 1'b0;
    tick(); tick();
    check("p1 done1", {30'd0, done1, done0}, 2);

    // Starvation guard with both ports streaming AD
    req0_valid = 1'b1; req0_op = 3'd0;
    req1_valid = 1'b1; req1_op = 3'd0;
    for (int k = 0; k < 8; k++) begin
      found = 0;
      for (int t = 0; t < 10 && found == 0; t++) begin
        tick();
        if (alu_start) begin
          found = 1;
          launch_cyc[k] = cyc;
          launch_gnt[k] = 32'(grant);
        end
      end
      check("stv launch seen", 32'(found), 1);
      if (found == 0) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stv grant[%0d]", k), 32'(launch_gnt[k]), (k == 3 || k == 7) ? 1 : 0);
      if (k > 0) check($sformatf("stv gap[%0d]", k), 32'(launch_cyc[k] - launch_cyc[k-1]), 3);
    end
    tick(); tick();
    check("stv done1", 32'(done1), 1);

    // Illegal ops
    req1_valid = 1'b1; req1_op = 3'd2;
    tick();
    check("ill1 ack/err", {30'd0, ack1, err}, 3);
    check("ill1 start/busy", {30'd0, alu_start, busy}, 0);
    check("ill1 op/grant", {28'd0, alu_op, grant}, 32'h1);
    req1_valid = 1'b0;
    tick();
    check("ill1 after", {28'd0, done1, err, busy, ack1}, 0);
    req0_valid = 1'b1; req0_op = 3'd7;
    tick();
    check("ill0 ack/err", {29'd0, ack0, err, alu_start}, 6);
    check("ill0 grant", 32'(grant), 1);
    req0_valid = 1'b0;
    tick();
    check("ill0 after", {29'd0, err, busy, ack0}, 0);

    // Reset during MP1
    req0_valid = 1'b1; req0_op = 3'd4;
    tick();
    check("mp1 start", {28'd0, alu_op, alu_start}, 32'h9);
    req0_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1 check_all_zero("async rst");
    req0_valid = 1'b1; req0_op = 3'd0;
    tick();
    check_all_zero("rst hold");
    rst = 1'b0;
    tick();
    check("post rst ack0", {29'd0, ack0, alu_start, done0}, 6);
    check("post rst op", 32'(alu_op), 0);
    req0_valid = 1'b0;
    tick();
    check("post rst no done", 32'(done0), 0);
    tick();
    check("post rst ad done", 32'(done0), 1);

    // Back-to-back SU then MP0
    req0_valid = 1'b1; req0_op = 3'd1;
    tick();
    check("b2b su start", {28'd0, alu_op, alu_start}, 32'h3);
    req0_op = 3'd3;
    tick(); tick();
    check("b2b su done", {30'd0, done0, alu_start}, 2);
    tick();
    check("b2b mp0 start", {27'd0, ack0, alu_op, alu_start}, 32'h17);
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b mp0 wait", 32'(done0), 0);
    end
    tick();
    check("b2b mp0 done", {30'd0, done0, busy}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameters: LAT_ADD default 2 (cycles, AD/SU/MASK); LAT_MP default 4 (MP0/MP1); LAT_DV default 6 (DV0/DV1); STARVE_MAX default 3 (consecutive port-0 wins while port 1 waits).
REQ-002 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  instruction-sequencer request.
- req0_op  in  3  op: AD=0, SU=1, MASK=2, MP0=3, MP1=4, DV0=5, DV1=6.
- req1_valid  in  1  counter-increment unit request.
- req1_op  in  3  same encoding as req0_op.
- ack0, ack1  out  1  each: one-cycle acceptance pulse.
- done0, done1  out  1  each: one-cycle completion pulse.
- err  out  1  one-cycle illegal-op pulse.
- alu_start  out  1  one-cycle launch pulse to ALU.
- alu_op  out  3  op driven to ALU.
- busy  out  1  op in flight.
- grant  out  1  port owning current/last op.

Function
REQ-003 SHALL implement states IDLE and EXEC; busy = (state==EXEC).
REQ-004 A requester SHALL hold valid and op stable until its ack pulse; the request is consumed by that ack.
REQ-005 In IDLE, arbitration at each clock edge SHALL follow these rules.
- Only one port valid: that port wins.
- Both ports valid: port 0 wins, unless starve count == STARVE_MAX, in which case port 1 wins.
REQ-006 Starve count (2 bits) SHALL behave as follows.
- Increments on each port-0 win while req1_valid=1.
- Clears on a port-1 win, or whenever req1_valid=0 at an arbitration edge.
- Saturates at STARVE_MAX.
REQ-007 Illegal ops SHALL be op=7 on either port, or any op other than AD/SU on port 1.
REQ-008 Legal win at edge E SHALL produce, in the cycle after E (cycle A):
- ackN=1, alu_start=1, alu_op=op, grant=N;
- state EXEC, down-counter loaded with LAT(op)-1.
REQ-009 Illegal win at edge E SHALL produce, in cycle A:
- ackN=1 and err=1;
- no alu_start and no done;
- alu_op and grant unchanged; state stays IDLE;
- starve count still updated per REQ-006.
REQ-010 In EXEC, the counter SHALL decrement each cycle; at counter==0, state SHALL return to IDLE and done[grant] SHALL pulse in the next cycle (cycle A+LAT).
REQ-011 No arbitration SHALL occur in EXEC; requests wait.
REQ-012 In the done cycle the block is IDLE and SHALL be able to accept a new request at that cycle's closing edge, giving back-to-back throughput of one op per LAT+1 cycles.
REQ-013 alu_op SHALL hold its value from cycle A until the next legal acceptance.
REQ-014 ack, done, err and alu_start SHALL each be high for exactly one cycle per event, and SHALL never assert for both ports in the same cycle.
REQ-015 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-016 rst=1 SHALL immediately force the following, regardless of clk:
- state IDLE;
- counter, starve count, alu_op, grant = 0;
- ack0/1, done0/1, err, alu_start, busy = 0.
REQ-017 Reset during EXEC SHALL drop the in-flight op: no done pulse after release.
REQ-018 The first arbitration SHALL occur at the first clk edge after rst deasserts.

Verification
REQ-019 Single AD: req0_valid=1, req0_op=0 -> in cycle A, ack0, alu_start and alu_op=0; busy high in A, A+1; done0 in A+2 with busy=0.
REQ-020 DV0 latency: req0_op=5 -> busy high for 6 cycles; done0 exactly 6 cycles after alu_start; req1 held valid is not acked during EXEC.
REQ-021 Starvation guard: both ports continuously valid, port-0 AD stream, port-1 op=0 -> grant sequence 0,0,0,1,0,0,0,1; each port-1 op launches LAT_ADD+1 cycles after the prior launch.
REQ-022 Illegal ops: req1_op=2 (MASK) -> ack1 and err in the same cycle; no alu_start, no done1, busy stays 0. req0_op=7 -> ack0 and err.
REQ-023 Reset mid-op: assert rst 2 cycles into MP1 (op 4) -> all outputs 0 asynchronously; no done0 after release; a new AD request is accepted at the first edge after release.
REQ-024 Back-to-back: req0 valid with ops SU then MP0 -> second alu_start in the same cycle as the first done0 + 1, i.e. 3 cycles after the first alu_start.
